// File: rtl/instr_queue.sv
// Instruction-fetch queue: issues one sequential fetch at a time, buffers returned words with PCs.
// Optional IQ_JAL_PREDICT_EN redirects fetch to the target of queued JAL instructions.
module instr_queue #(
  parameter int unsigned IqDepthLog = 4,
  parameter logic [31:0] ResetPc    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_stall_from_ft,
  input  logic        is_finish_from_ft,
  input  logic        is_instr_from_ft,
  input  logic [31:0] data_from_ft,
  output logic        is_empty_to_ft,
  output logic [31:0] addr_to_ft,
  output logic        is_receive_to_ft,
  input  logic        is_ready_from_dc,
  output logic        is_valid_to_dc,
  output logic [31:0] instr_to_dc,
  output logic [31:0] pc_to_dc,
  input  logic        is_clear_from_rob,
  input  logic [31:0] pc_from_rob
);

  localparam int unsigned Depth = 1 << IqDepthLog;
  localparam logic [IqDepthLog:0]   DepthCnt = {1'b1, {IqDepthLog{1'b0}}};
  localparam logic [IqDepthLog:0]   CntOne   = 1;
  localparam logic [IqDepthLog-1:0] PtrOne   = 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [31:0]           req_pc_q, req_pc_d;
  logic [IqDepthLog-1:0] head_q, head_d, tail_q, tail_d;
  logic [IqDepthLog:0]   count_q, count_d;
  logic                  discard_q, discard_d;
  logic [31:0]           instr_mem_q [Depth];
  logic [31:0]           pc_mem_q    [Depth];

  logic req_fire, recv, enq, deq;

`ifdef IQ_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm = {{11{data_from_ft[31]}}, data_from_ft[31], data_from_ft[19:12],
                    data_from_ft[20], data_from_ft[30:21], 1'b0};
`endif

  assign req_fire         = (state_q == StReq) && !is_stall_from_ft;
  assign recv             = (state_q == StWait) && is_finish_from_ft && is_instr_from_ft;
  assign enq              = recv && !discard_q && !is_clear_from_rob;
  assign is_valid_to_dc   = (count_q != '0);
  assign deq              = is_valid_to_dc && is_ready_from_dc && !is_clear_from_rob;
  assign is_empty_to_ft   = (state_q != StReq);
  assign addr_to_ft       = fetch_pc_q;
  assign is_receive_to_ft = recv;
  assign instr_to_dc      = is_valid_to_dc ? instr_mem_q[head_q] : '0;
  assign pc_to_dc         = is_valid_to_dc ? pc_mem_q[head_q] : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    discard_d  = discard_q;

    unique case (state_q)
      StIdle: begin
        // Issue only while a slot is free for the word that will come back.
        if (count_q < DepthCnt) state_d = StReq;
      end
      StReq: begin
        if (req_fire) begin
          state_d    = StWait;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      StWait: begin
        if (recv) begin
          state_d   = StIdle;
          discard_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enq) begin
      tail_d = tail_q + PtrOne;
`ifdef IQ_JAL_PREDICT_EN
      if (data_from_ft[6:0] == 7'b1101111) fetch_pc_d = req_pc_q + jal_imm;
`endif
    end
    if (deq) head_d = head_q + PtrOne;

    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    if (is_clear_from_rob) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = pc_from_rob;
      // A request that is (or was just) in flight must have its word dropped on return.
      if (req_fire || ((state_q == StWait) && !recv)) begin
        state_d   = StWait;
        discard_d = 1'b1;
      end else begin
        state_d   = StIdle;
        discard_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPc;
      req_pc_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (enq) begin
      instr_mem_q[tail_q] <= data_from_ft;
      pc_mem_q[tail_q]    <= req_pc_q;
    end
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Instruction-fetch queue; sits directly upstream of the memory fetcher and downstream of nothing but the PC.
- Generates sequential instruction-address requests to the fetcher, one outstanding at a time, and accepts returned 32-bit words.
- Buffers the returned words with their PCs in a FIFO and hands them in order to the decoder.
- Supports a full flush and redirect on a clear from the commit side.

Parameters:
IqDepthLog, 4, log2 of queue depth (16 entries)
ResetPc, 32'h0, PC of first fetch after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
is_stall_from_ft  in  1  fetcher cannot accept a request this cycle
is_finish_from_ft  in  1  fetcher head entry complete; data valid
is_instr_from_ft  in  1  completed entry is an instruction fetch
data_from_ft  in  32  returned instruction word
is_empty_to_ft  out  1  0 = request valid this cycle
addr_to_ft  out  32  request address
is_receive_to_ft  out  1  consume completed instruction (combinational)
is_ready_from_dc  in  1  decoder accepts head
is_valid_to_dc  out  1  queue head valid
instr_to_dc  out  32  head instruction
pc_to_dc  out  32  head PC
is_clear_from_rob  in  1  flush and redirect
pc_from_rob  in  32  redirect target

Behaviour:
- Reset (rst=0, asynchronous), all regs cleared: state=IDLE, fetch_pc=ResetPc, head=tail=count=0, discard=0, is_empty_to_ft=1, is_valid_to_dc=0, instr/pc outputs 0.
- FSM IDLE:
  - If count+1 <= depth (space for the outstanding word) and no clear, go to REQ.
- FSM REQ:
  - Drive is_empty_to_ft=0, addr_to_ft=fetch_pc.
  - If is_stall_from_ft=0 at clk edge, request is accepted; go to WAIT, latch req_pc=fetch_pc, fetch_pc+=4.
  - Else hold all outputs.
- FSM WAIT:
  - is_empty_to_ft=1.
  - is_receive_to_ft = is_finish_from_ft & is_instr_from_ft; no other state ever asserts it.
  - On receive: if discard=0, enqueue {data_from_ft, req_pc} at tail, tail++, count++. If discard=1, drop the word and clear discard. Then go to IDLE.
- Dequeue: is_valid_to_dc=(count!=0); head entry drives instr/pc combinationally. valid&ready at edge: head++, count--.
- Simultaneous enqueue and dequeue: count unchanged.
- Pointers are IqDepthLog bits and wrap naturally. Count is IqDepthLog+1 bits.
- Full condition: count=depth. Because space is reserved before request issue, enqueue never overflows.
- Clear has highest priority:
  - head=tail=count=0, fetch_pc=pc_from_rob, state=IDLE.
  - If clear occurs in WAIT with no receive that same cycle, set discard=1 and stay in WAIT; the stale word is drained and dropped.
  - If clear coincides with receive, drop the word; discard stays 0.
  - Clear in REQ withdraws the request (accepted-same-cycle request is also treated as stale: go WAIT with discard=1).
  - is_valid_to_dc=0 the cycle after clear.
- Addresses are byte addresses; +4 is modulo 2^32.
- Throughput: at most one request in flight; fetch latency is set by the fetcher.

Optional Feature:
- Macro: IQ_JAL_PREDICT_EN.
- With it: on a non-discarded enqueue whose word[6:0]=7'b1101111 (JAL), set fetch_pc = req_pc + sext({w[31],w[19:12],w[20],w[30:21],1'b0}). This overrides the +4 applied at issue; IDLE next issues the target.
- Without it: fetch is strictly sequential; JAL words are queued like any other.
- Clear always overrides prediction.

Test Plan:
1. Reset: rst low mid-WAIT, then high; ResetPc=0, fetcher returns 0x00000013 after 4 cycles -> addr_to_ft=0; dc sees instr 0x00000013, pc 0; next request addr=4.
2. Stall: is_stall_from_ft=1 for 3 cycles in REQ -> addr_to_ft held at 0x8, is_empty_to_ft=0 throughout; accepted on cycle 4, no duplicate request.
3. Full: is_ready_from_dc=0, return 16 words -> count=16, no 17th request issued; one pop -> exactly one new request.
4. Clear during WAIT: clear with pc_from_rob=0x100 while fetch of 0x20 outstanding -> returned word is dropped with is_receive_to_ft=1; next request addr 0x100; queue empty.
5. Simultaneous: pop and enqueue in same cycle at count=5 -> count stays 5, order preserved across pointer wrap from 15 to 0.
6. IQ_JAL_PREDICT_EN: word 0x0080006F (jal x0,+8) fetched at pc 0x40 -> next request 0x48; without the macro -> next request 0x44.
